// File: rtl/axi_txn_sequencer_if.sv
// Command/response and channel-control bundle between the test sequencer,
// the transaction sequencer and the AXI manager/subordinate testbench models.
interface axi_txn_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] mgr_tx_AW;
    logic [DATA_W-1:0] mgr_tx_W;
    logic [ADDR_W-1:0] mgr_tx_AR;
    logic [4:0]        tx_en;
    logic [4:0]        sub_new_data;
    logic [4:0]        mgr_new_data;
    logic [1:0]        mgr_bresp;
    logic [1:0]        mgr_rresp;
    logic [DATA_W-1:0] mgr_rx_R;
    logic              rsp_valid;
    logic [1:0]        rsp_resp;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output sub_new_data, mgr_new_data, mgr_bresp, mgr_rresp, mgr_rx_R,
        input  cmd_ready, mgr_tx_AW, mgr_tx_W, mgr_tx_AR, tx_en,
        input  rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  sub_new_data, mgr_new_data, mgr_bresp, mgr_rresp, mgr_rx_R,
        output cmd_ready, mgr_tx_AW, mgr_tx_W, mgr_tx_AR, tx_en,
        output rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, busy
    );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Single-transaction AXI sequencer: steps channel enables AW+W -> B or AR -> R,
// using per-channel new-data flags as completion, with a per-phase timeout.
module axi_txn_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_txn_sequencer_if.slave txn
);
    localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WR_AD, WR_B, RD_A, RD_R, RESP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    wr_left;
    logic          phase_hit;
    logic          timeout_now;
    logic          unused_flags;

    // A cleared AW/W enable doubles as that channel's sticky done bit.
    assign wr_left = txn.tx_en[4:3] & ~txn.sub_new_data[4:3];

    always_comb begin
        phase_hit = 1'b1;
        case (state)
            WR_AD:   phase_hit = (wr_left == 2'b00);
            WR_B:    phase_hit = txn.mgr_new_data[2];
            RD_A:    phase_hit = txn.sub_new_data[1];
            RD_R:    phase_hit = txn.mgr_new_data[0];
            default: phase_hit = 1'b1;
        endcase
    end

    // A completion arriving on the expiry cycle takes priority over the timeout.
    assign timeout_now = (timer >= T_LAST) && !phase_hit;

    assign unused_flags = ^{txn.sub_new_data[2], txn.sub_new_data[0],
                            txn.mgr_new_data[4:3], txn.mgr_new_data[1]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state           <= IDLE;
            timer           <= '0;
            txn.tx_en       <= '0;
            txn.mgr_tx_AW   <= '0;
            txn.mgr_tx_W    <= '0;
            txn.mgr_tx_AR   <= '0;
            txn.rsp_valid   <= 1'b0;
            txn.rsp_resp    <= 2'b00;
            txn.rsp_rdata   <= '0;
            txn.rsp_timeout <= 1'b0;
            txn.cmd_ready   <= 1'b1;
            txn.busy        <= 1'b0;
        end else begin
            txn.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (txn.cmd_valid && txn.cmd_ready) begin
                        txn.cmd_ready <= 1'b0;
                        txn.busy      <= 1'b1;
                        timer         <= '0;
                        if (txn.cmd_write) begin
                            txn.mgr_tx_AW <= txn.cmd_addr;
                            txn.mgr_tx_W  <= txn.cmd_wdata;
                            txn.tx_en     <= 5'b11000;
                            state         <= WR_AD;
                        end else begin
                            txn.mgr_tx_AR <= txn.cmd_addr;
                            txn.tx_en     <= 5'b00010;
                            state         <= RD_A;
                        end
                    end
                end
                WR_AD, WR_B, RD_A, RD_R: begin
                    if (timeout_now) begin
                        txn.tx_en       <= '0;
                        txn.rsp_resp    <= 2'b10;
                        txn.rsp_timeout <= 1'b1;
                        txn.rsp_rdata   <= '0;
                        txn.rsp_valid   <= 1'b1;
                        timer           <= '0;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                        case (state)
                            WR_AD: begin
                                if (txn.tx_en[4:3] == 2'b00) begin
                                    txn.tx_en <= 5'b00100;
                                    timer     <= '0;
                                    state     <= WR_B;
                                end else begin
                                    txn.tx_en[4:3] <= wr_left;
                                end
                            end
                            WR_B: begin
                                if (txn.mgr_new_data[2]) begin
                                    txn.rsp_resp    <= txn.mgr_bresp;
                                    txn.rsp_rdata   <= '0;
                                    txn.rsp_timeout <= 1'b0;
                                    txn.rsp_valid   <= 1'b1;
                                    txn.tx_en       <= '0;
                                    timer           <= '0;
                                    state           <= RESP;
                                end
                            end
                            RD_A: begin
                                if (txn.sub_new_data[1]) begin
                                    txn.tx_en <= 5'b00001;
                                    timer     <= '0;
                                    state     <= RD_R;
                                end
                            end
                            RD_R: begin
                                if (txn.mgr_new_data[0]) begin
                                    txn.rsp_resp    <= txn.mgr_rresp;
                                    txn.rsp_rdata   <= txn.mgr_rx_R;
                                    txn.rsp_timeout <= 1'b0;
                                    txn.rsp_valid   <= 1'b1;
                                    txn.tx_en       <= '0;
                                    timer           <= '0;
                                    state           <= RESP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    txn.cmd_ready <= 1'b1;
                    txn.busy      <= 1'b0;
                    timer         <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Directed bench for axi_txn_sequencer: inputs driven and outputs checked on
// the falling clock edge; cycle offsets are counted from the accepting edge.
module tb_axi_txn_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axi_txn_sequencer_if #(.ADDR_W(32), .DATA_W(64)) txn ();

    axi_txn_sequencer #(
        .ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n), .txn(txn)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [63:0] d);
        txn.cmd_valid = 1'b1;
        txn.cmd_write = wr;
        txn.cmd_addr  = a;
        txn.cmd_wdata = d;
    endtask

    // Write with AW and W completing together; called at an idle falling edge.
    task automatic wr_same_cycle(input logic [31:0] a, input logic [63:0] d, input logic [1:0] br);
        send(1'b1, a, d);
        cyc();
        chk("sc_en_aw_w", txn.tx_en, 5'b11000);
        chk("sc_aw", txn.mgr_tx_AW, a);
        chk("sc_w", txn.mgr_tx_W, d);
        txn.cmd_valid    = 1'b0;
        txn.sub_new_data = 5'b11000;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("sc_both_drop", txn.tx_en, 5'b00000);
        cyc();
        chk("sc_en_b", txn.tx_en, 5'b00100);
        txn.mgr_new_data = 5'b00100;
        txn.mgr_bresp    = br;
        cyc();
        txn.mgr_new_data = 5'b00000;
        chk("sc_rsp_valid", txn.rsp_valid, 1'b1);
        chk("sc_rsp_resp", txn.rsp_resp, br);
        chk("sc_rsp_rdata", txn.rsp_rdata, 64'h0);
        chk("sc_rsp_to", txn.rsp_timeout, 1'b0);
        cyc();
        chk("sc_pulse_end", txn.rsp_valid, 1'b0);
        chk("sc_ready", txn.cmd_ready, 1'b1);
    endtask

    initial begin
        txn.cmd_valid    = 1'b0;
        txn.cmd_write    = 1'b0;
        txn.cmd_addr     = '0;
        txn.cmd_wdata    = '0;
        txn.sub_new_data = '0;
        txn.mgr_new_data = '0;
        txn.mgr_bresp    = '0;
        txn.mgr_rresp    = '0;
        txn.mgr_rx_R     = '0;

        // Reset values
        cyc();
        chk("rst_tx_en", txn.tx_en, 5'b00000);
        chk("rst_ready", txn.cmd_ready, 1'b1);
        chk("rst_busy", txn.busy, 1'b0);
        chk("rst_valid", txn.rsp_valid, 1'b0);
        chk("rst_resp", txn.rsp_resp, 2'b00);
        chk("rst_aw", txn.mgr_tx_AW, 32'h0);
        chk("rst_rdata", txn.rsp_rdata, 64'h0);
        rst_n = 1'b1;
        cyc();

        // Write 0x1000 with staggered AW/W flags
        send(1'b1, 32'h1000, 64'hDEAD_BEEF_0123_4567);
        cyc();
        txn.cmd_valid = 1'b0;
        chk("w1_en_p1", txn.tx_en, 5'b11000);
        chk("w1_aw", txn.mgr_tx_AW, 32'h1000);
        chk("w1_w", txn.mgr_tx_W, 64'hDEAD_BEEF_0123_4567);
        chk("w1_busy", txn.busy, 1'b1);
        chk("w1_ready", txn.cmd_ready, 1'b0);
        cyc();
        chk("w1_en_p2", txn.tx_en, 5'b11000);
        txn.sub_new_data = 5'b10000;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("w1_en_p3", txn.tx_en, 5'b01000);
        cyc();
        chk("w1_en_p4", txn.tx_en, 5'b01000);
        txn.sub_new_data = 5'b01000;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("w1_en_p5", txn.tx_en, 5'b00000);
        cyc();
        chk("w1_en_p6", txn.tx_en, 5'b00100);
        cyc();
        chk("w1_en_p7", txn.tx_en, 5'b00100);
        chk("w1_novalid_p7", txn.rsp_valid, 1'b0);
        txn.mgr_new_data = 5'b00100;
        txn.mgr_bresp    = 2'b00;
        cyc();
        txn.mgr_new_data = 5'b00000;
        chk("w1_valid_p8", txn.rsp_valid, 1'b1);
        chk("w1_resp", txn.rsp_resp, 2'b00);
        chk("w1_to", txn.rsp_timeout, 1'b0);
        chk("w1_en_p8", txn.tx_en, 5'b00000);
        cyc();
        chk("w1_valid_p9", txn.rsp_valid, 1'b0);
        chk("w1_ready_p9", txn.cmd_ready, 1'b1);
        chk("w1_busy_p9", txn.busy, 1'b0);

        // Write with simultaneous AW and W completion
        wr_same_cycle(32'h1100, 64'h55, 2'b11);

        // Read 0x2000, rresp=01
        send(1'b0, 32'h2000, 64'h0);
        cyc();
        txn.cmd_valid = 1'b0;
        chk("r1_en_ar", txn.tx_en, 5'b00010);
        chk("r1_ar", txn.mgr_tx_AR, 32'h2000);
        chk("r1_aw_hold", txn.mgr_tx_AW, 32'h1100);
        txn.sub_new_data = 5'b00010;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("r1_en_r", txn.tx_en, 5'b00001);
        txn.mgr_new_data = 5'b00001;
        txn.mgr_rx_R     = 64'hCAFE;
        txn.mgr_rresp    = 2'b01;
        cyc();
        txn.mgr_new_data = 5'b00000;
        chk("r1_valid", txn.rsp_valid, 1'b1);
        chk("r1_rdata", txn.rsp_rdata, 64'hCAFE);
        chk("r1_resp", txn.rsp_resp, 2'b01);
        chk("r1_en_off", txn.tx_en, 5'b00000);
        cyc();
        chk("r1_pulse_end", txn.rsp_valid, 1'b0);
        chk("r1_resp_hold", txn.rsp_resp, 2'b01);
        chk("r1_ready", txn.cmd_ready, 1'b1);

        // Read with no R flag: times out after 8 cycles in RD_R
        send(1'b0, 32'h3000, 64'h0);
        cyc();
        txn.cmd_valid = 1'b0;
        chk("to_en_ar", txn.tx_en, 5'b00010);
        txn.sub_new_data = 5'b00010;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("to_en_r", txn.tx_en, 5'b00001);
        repeat (7) cyc();
        chk("to_en_last", txn.tx_en, 5'b00001);
        chk("to_novalid", txn.rsp_valid, 1'b0);
        cyc();
        chk("to_en_off", txn.tx_en, 5'b00000);
        chk("to_valid", txn.rsp_valid, 1'b1);
        chk("to_resp", txn.rsp_resp, 2'b10);
        chk("to_flag", txn.rsp_timeout, 1'b1);
        chk("to_rdata", txn.rsp_rdata, 64'h0);
        cyc();
        chk("to_pulse_end", txn.rsp_valid, 1'b0);
        chk("to_flag_hold", txn.rsp_timeout, 1'b1);
        chk("to_ready", txn.cmd_ready, 1'b1);

        // Spurious flags during WR_AD, cmd_valid held while busy
        send(1'b1, 32'h4000, 64'h1234);
        cyc();
        chk("sp_en_p1", txn.tx_en, 5'b11000);
        txn.cmd_write    = 1'b0;
        txn.cmd_addr     = 32'h5000;
        txn.mgr_new_data = 5'b00101;
        txn.sub_new_data = 5'b00010;
        cyc();
        chk("sp_en_p2", txn.tx_en, 5'b11000);
        chk("sp_ready", txn.cmd_ready, 1'b0);
        chk("sp_busy", txn.busy, 1'b1);
        chk("sp_ar_hold", txn.mgr_tx_AR, 32'h3000);
        txn.mgr_new_data = 5'b00000;
        txn.sub_new_data = 5'b11000;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("sp_en_p3", txn.tx_en, 5'b00000);
        cyc();
        chk("sp_en_b", txn.tx_en, 5'b00100);
        txn.mgr_new_data = 5'b00100;
        txn.mgr_bresp    = 2'b00;
        cyc();
        txn.mgr_new_data = 5'b00000;
        chk("sp_valid", txn.rsp_valid, 1'b1);
        chk("sp_to_clear", txn.rsp_timeout, 1'b0);
        chk("sp_resp", txn.rsp_resp, 2'b00);
        chk("sp_ready_resp", txn.cmd_ready, 1'b0);
        cyc();
        chk("sp_ready_idle", txn.cmd_ready, 1'b1);
        chk("sp_en_idle", txn.tx_en, 5'b00000);
        cyc();
        txn.cmd_valid = 1'b0;
        chk("sp2_en_ar", txn.tx_en, 5'b00010);
        chk("sp2_ar", txn.mgr_tx_AR, 32'h5000);
        txn.sub_new_data = 5'b00010;
        cyc();
        txn.sub_new_data = 5'b00000;
        chk("sp2_en_r", txn.tx_en, 5'b00001);
        txn.mgr_new_data = 5'b00001;
        txn.mgr_rx_R     = 64'h0123_4567_89AB_CDEF;
        txn.mgr_rresp    = 2'b00;
        cyc();
        txn.mgr_new_data = 5'b00000;
        chk("sp2_valid", txn.rsp_valid, 1'b1);
        chk("sp2_rdata", txn.rsp_rdata, 64'h0123_4567_89AB_CDEF);
        cyc();
        chk("sp2_ready", txn.cmd_ready, 1'b1);

        // Reset asserted during WR_B
        send(1'b1, 32'h6000, 64'hAAAA);
        cyc();
        txn.cmd_valid    = 1'b0;
        txn.sub_new_data = 5'b11000;
        cyc();
        txn.sub_new_data = 5'b00000;
        cyc();
        chk("rb_en_b", txn.tx_en, 5'b00100);
        rst_n = 1'b0;
        txn.mgr_new_data = 5'b00100;
        #1;
        chk("rb_en_async", txn.tx_en, 5'b00000);
        chk("rb_busy", txn.busy, 1'b0);
        chk("rb_ready", txn.cmd_ready, 1'b1);
        chk("rb_aw_clr", txn.mgr_tx_AW, 32'h0);
        cyc();
        chk("rb_novalid_rst", txn.rsp_valid, 1'b0);
        rst_n = 1'b1;
        txn.mgr_new_data = 5'b00000;
        cyc();
        chk("rb_novalid_post", txn.rsp_valid, 1'b0);
        chk("rb_en_post", txn.tx_en, 5'b00000);
        wr_same_cycle(32'h7000, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
